mips_dmem_responder: RTL and testbench

Data-memory responder for the pipelined MIPS CPU's MEM stage. Accepts one load/store request at a time over a valid/ready handshake and returns a response after a fixed, parameterised wait-state latency. While a request is in flight it asserts a busy/stall indication so the pipeline can freeze. It is the memory-side counterpart of the CPU's MemRead/MemWrite/ALU-address outputs and replaces the zero-latency behavioural data memory in system simulation.

---
 rtl/mips_dmem_responder_pkg.sv | 6 +
 rtl/mips_dmem_responder_if.sv | 17 +
 rtl/mips_dmem_responder_array.sv | 19 +
 rtl/mips_dmem_responder.sv | 74 +++++++
 tb/tb_mips_dmem_responder.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/mips_dmem_responder_pkg.sv
// dmem_pkg: shared FSM state type and counter limits for the data-memory responder.
package dmem_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  localparam int CNT_W   = 4;
  localparam int LAT_MAX = 15;
endpackage

// File: rtl/mips_dmem_responder_if.sv
// mips_dmem_responder_if: CPU-side request/response bus of the data-memory responder.
interface mips_dmem_responder_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  modport master (output req_valid, req_write, req_addr, req_wdata, rsp_ready,
                  input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy);
  modport slave  (input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
                  output req_ready, rsp_valid, rsp_rdata, rsp_err, busy);
endinterface

// File: rtl/mips_dmem_responder_array.sv
// dmem_array: single-port word array, synchronous write and synchronous read.
module dmem_array #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);
  logic [31:0] mem_q [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      rdata_o <= mem_q[addr_i];
    end
  end
endmodule

// File: rtl/mips_dmem_responder.sv
// mips_dmem_responder: fixed-latency load/store responder for the MEM stage.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned accesses via rsp_err and suppress them.
module mips_dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  mips_dmem_responder_if.slave   bus
);
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wr_q, err_q, mis, accept, mem_en;
  logic [ADDR_W-1:0]  idx_q;
  logic [31:0]        wdata_q, rdata;
`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis = |bus.req_addr[1:0];
`else
  assign mis = 1'b0;
`endif
  assign accept = state_q == S_IDLE && bus.req_valid;
  // Array is touched only on the edge that enters RESP, so a reset in WAIT drops the store.
  assign mem_en = state_q == S_WAIT && cnt_q == '0;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: if (accept) begin
        state_d = S_WAIT;
        cnt_d   = CNT_W'(LATENCY > LAT_MAX ? LAT_MAX : LATENCY);
      end
      S_WAIT: begin
        state_d = cnt_q == '0 ? S_RESP : S_WAIT;
        cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
      end
      S_RESP:  state_d = bus.rsp_ready ? S_IDLE : S_RESP;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q    <= bus.req_write;
        err_q   <= mis;
        idx_q   <= bus.req_addr[ADDR_W+1:2];
        wdata_q <= bus.req_wdata;
      end
    end
  end
  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk     (clk),
    .en_i    (mem_en),
    .we_i    (wr_q & ~err_q),
    .addr_i  (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (rdata)
  );
  assign bus.req_ready = state_q == S_IDLE;
  assign bus.busy      = state_q != S_IDLE;
  assign bus.rsp_valid = state_q == S_RESP;
  assign bus.rsp_err   = state_q == S_RESP && err_q;
  assign bus.rsp_rdata = (state_q == S_RESP && !wr_q && !err_q) ? rdata : 32'h0;
endmodule

// File: tb/tb_mips_dmem_responder.sv
// tb_mips_dmem_responder: directed checks of the responder at LATENCY=2 and LATENCY=0.
module tb_mips_dmem_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  mips_dmem_responder_if bus ();
  mips_dmem_responder_if bus0 ();
  mips_dmem_responder #(.ADDR_W(8), .LATENCY(2)) u_dut (.clk(clk), .reset(reset), .bus(bus));
  mips_dmem_responder #(.ADDR_W(8), .LATENCY(0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int lat);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, nb;

  initial begin
    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = 0; bus.req_wdata = 0; bus.rsp_ready = 0;
    bus0.req_valid = 0; bus0.req_write = 0; bus0.req_addr = 0; bus0.req_wdata = 0; bus0.rsp_ready = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;

    xact(1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
    chk("st_latency", 32'(lat), 32'd3);
    chk("st_rdata", rd, 32'h0);
    chk("st_err", 32'(er), 32'd0);
    chk("st_idle_after", 32'(bus.busy), 32'd0);
    xact(1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("ld_latency", 32'(lat), 32'd3);
    chk("ld_rdata", rd, 32'hDEADBEEF);
    xact(1'b0, 32'hFFFF_0010, 32'h0, rd, er, lat);
    chk("ld_high_bits", rd, 32'hDEADBEEF);

    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h10;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
    chk("ready_after_accept", 32'(bus.req_ready), 32'd0);
    nb = 0;
    while (!bus.rsp_valid && nb < 40) begin
      @(posedge clk); #1;
      nb++;
    end
    chk("hold_latency", 32'(nb), 32'd3);
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h10; bus.req_wdata = 32'hBAD0BAD0;
      @(posedge clk); #1;
      chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_rdata", bus.rsp_rdata, 32'hDEADBEEF);
      chk("hold_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("hs_valid_low", 32'(bus.rsp_valid), 32'd0);
    chk("hs_rdata_zero", bus.rsp_rdata, 32'h0);
    chk("hs_busy_low", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    chk("ignored_no_accept", 32'(bus.busy), 32'd0);
    xact(1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("ignored_no_write", rd, 32'hDEADBEEF);

    xact(1'b1, 32'h400, 32'h12345678, rd, er, lat);
    xact(1'b0, 32'h000, 32'h0, rd, er, lat);
    chk("wrap_ld", rd, 32'h12345678);

    xact(1'b1, 32'h20, 32'h11112222, rd, er, lat);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h20; bus.req_wdata = 32'hAAAA5555;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_rdata", bus.rsp_rdata, 32'h0);
    chk("midrst_ready", 32'(bus.req_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_stays_idle", 32'(bus.rsp_valid), 32'd0);
    xact(1'b0, 32'h20, 32'h0, rd, er, lat);
    chk("midrst_no_commit", rd, 32'h11112222);

`ifdef DMEM_MISALIGN_TRAP_EN
    xact(1'b1, 32'h13, 32'h5A5A5A5A, rd, er, lat);
    chk("mis_st_err", 32'(er), 32'd1);
    chk("mis_st_rdata", rd, 32'h0);
    chk("mis_st_latency", 32'(lat), 32'd3);
    xact(1'b0, 32'h13, 32'h0, rd, er, lat);
    chk("mis_ld_err", 32'(er), 32'd1);
    chk("mis_ld_rdata", rd, 32'h0);
    xact(1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("mis_unchanged", rd, 32'hDEADBEEF);
    chk("mis_aligned_err", 32'(er), 32'd0);
`else
    xact(1'b0, 32'h13, 32'h0, rd, er, lat);
    chk("lowbits_ld", rd, 32'hDEADBEEF);
    chk("lowbits_err", 32'(er), 32'd0);
`endif

    bus0.req_valid = 1'b1; bus0.req_write = 1'b1; bus0.req_addr = 32'h44; bus0.req_wdata = 32'hCAFEF00D;
    bus0.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    nb = 0;
    while (bus0.busy && nb < 40) begin
      @(posedge clk); #1;
      nb++;
    end
    chk("l0_st_busy_cycles", 32'(nb), 32'd2);
    bus0.req_valid = 1'b1; bus0.req_write = 1'b0; bus0.req_addr = 32'h44; bus0.rsp_ready = 1'b0;
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    chk("l0_busy", 32'(bus0.busy), 32'd1);
    chk("l0_not_yet", 32'(bus0.rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk("l0_rsp_valid", 32'(bus0.rsp_valid), 32'd1);
    chk("l0_rdata", bus0.rsp_rdata, 32'hCAFEF00D);
    bus0.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus0.rsp_ready = 1'b0;
    chk("l0_busy_low", 32'(bus0.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
